rx_word: RTL and testbench
==========================

# rx_word

Receive-side counterpart of the correlator's hex word transmitter. Deserialises an asynchronous 8N1 UART stream of ASCII hexadecimal characters, most-significant nibble first and terminated by carriage return (0x0D), into a RESOLUTION-bit word. Presents each complete word with a one-cycle valid strobe. Sits at the host-command input of the correlator and loads configuration words sent from the PC.

## Interface

Parameters:
- RESOLUTION, 32: output word width in bits; must be a multiple of 4.
- TOTAL_NIBBLES, RESOLUTION/4: number of hex digits required per word.
- CLKS_PER_BIT, 8: `clk` cycles per UART bit period; must be ≥ 4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RX  input  1  UART serial input; idle high; asynchronous to `clk`.
- rx_data  output  RESOLUTION  last correctly received word.
- rx_valid  output  1  one-cycle pulse when `rx_data` is updated.
- rx_error  output  1  one-cycle pulse when a terminated word is rejected.

## Operation

- Reset values:
  - `rx_data`, `rx_valid` and `rx_error` = 0.
  - Bit state machine in IDLE; digit count 0; error flag clear.
  - Synchroniser flops = 1.
- `RX` passes through a 2-flop synchroniser before any use.
- Bit state machine:
  - IDLE: on synced `RX` falling (previous 1, current 0) → START, timer cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample the line. If it is 1 (glitch) → IDLE with no byte. If it is 0 → DATA.
  - DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first, into a shift register → STOP.
  - STOP: sample once after CLKS_PER_BIT cycles.
    - Stop bit = 1: byte strobe, → IDLE.
    - Stop bit = 0: framing error, → WAIT_IDLE.
  - WAIT_IDLE: remain until the synced line is 1, then → IDLE.
- Character decoding on each byte strobe:
  - '0'–'9', 'A'–'F', 'a'–'f': shift the accumulator left 4 bits and insert the nibble. Digit count increments and saturates at TOTAL_NIBBLES+1.
  - 0x0A (LF): ignored, with no state change.
  - 0x0D (CR), terminating the word:
    - If digit count = 0 and the error flag is clear: no output (blank line).
    - Else, if digit count = TOTAL_NIBBLES and the error flag is clear: `rx_data` ← accumulator and `rx_valid` pulses.
    - Otherwise: `rx_error` pulses and `rx_data` is unchanged.
    - In every case, the digit count, accumulator and error flag are then cleared.
  - Any other byte: set the error flag.
- A framing error sets the error flag. The flag persists until the next CR.
- `rx_valid` and `rx_error` are never asserted in the same cycle.

## Timing

- Detection latency: the start edge is detected 2–3 cycles after `RX` falls (synchroniser delay).
- Sample points, measured from start-edge detection:
  - Mid-start sample: CLKS_PER_BIT/2 cycles.
  - Data bit i (0..7): CLKS_PER_BIT·(i+1) cycles after the mid-start sample.
  - Stop bit: 9·CLKS_PER_BIT cycles after the mid-start sample.
- The byte strobe is registered in the cycle after the stop sample.
- For a CR, `rx_valid`/`rx_error` and `rx_data` update on the edge following the byte strobe.
- Total latency is 2 cycles after the stop-bit sample.
- Back-to-back characters with zero idle time are supported: IDLE re-arms in the cycle after the stop sample.
- Reset asserted mid-character or mid-word discards all partial state immediately. The first character after release must begin with a fresh start edge.

## Test plan

All scenarios use CLKS_PER_BIT=8 and RESOLUTION=32.

1. Send "DEADBEEF\r" → exactly one `rx_valid` pulse, 2 cycles after the CR stop sample; `rx_data`=0xDEADBEEF; `rx_error` stays 0.
2. Send "0000001a\r\n" and then "FFFFFFFF\r", back-to-back with no idle bits.
   - After the first CR: `rx_data`=0x0000001A.
   - After the second CR: `rx_data`=0xFFFFFFFF.
   - Two `rx_valid` pulses in total; the LF has no effect.
3. Invalid content, each preceded by a good word 0x12345678:
   - "12G45678\r" → one `rx_error` pulse; `rx_data` stays 0x12345678.
   - "123\r" → one `rx_error` pulse; `rx_data` stays 0x12345678.
   - "123456789\r" → one `rx_error` pulse; `rx_data` stays 0x12345678.
   - "\r" alone → no pulse at all.
4. Send "AB" + a byte with stop bit 0 + "CDEF01\r" → no `rx_valid`; one `rx_error` pulse at the CR. A following "00000005\r" → `rx_data`=0x00000005.
5. Drive `RX` low for 2 cycles in IDLE, then high → no byte strobe and no output change. A following valid word is received correctly.
6. Assert `rst_n` low during the 5th digit of "CAFEBABE\r" → all outputs read 0 while in reset. After release, send "CAFEBABE\r" → `rx_data`=0xCAFEBABE and exactly one `rx_valid` pulse.

Source files
------------

// File: rtl/rx_word.sv
// Receive side of the correlator host link: 8N1 UART stream of ASCII hex digits,
// MS nibble first, CR-terminated, assembled into a RESOLUTION-bit word.
`timescale 1ns/1ps
module rx_word #(
    parameter int RESOLUTION    = 32,
    parameter int TOTAL_NIBBLES = RESOLUTION / 4,
    parameter int CLKS_PER_BIT  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX,
    output logic [RESOLUTION-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_error
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(TOTAL_NIBBLES + 2);
    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL_NIBBLES);
    localparam logic [CW-1:0] CNT_SAT  = CW'(TOTAL_NIBBLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q, prev_q;
    logic [TW-1:0]           timer_q, timer_d;
    logic [2:0]              bit_q, bit_d;
    logic [7:0]              shift_q, shift_d;
    logic [7:0]              byte_q, byte_d;
    logic                    byte_stb_q, byte_stb_d;
    logic                    frame_err_q, frame_err_d;
    logic [RESOLUTION-1:0]   acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [RESOLUTION-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_error_q, rx_error_d;
    logic [4:0]              dec;

    // Returns {is_hex_digit, nibble}.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (prev_q && !sync2_q)
                    state_d = S_START;
            end
            S_START: begin
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    bit_d   = 3'd0;
                    state_d = sync2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7)
                        state_d = S_STOP;
                    else
                        bit_d = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    if (sync2_q) begin
                        byte_stb_d = 1'b1;
                        byte_d     = shift_q;
                        state_d    = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                timer_d = '0;
                if (sync2_q)
                    state_d = S_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Character decoding and word assembly, one cycle behind the byte strobe.
    always_comb begin
        dec        = hex_nib(byte_q);
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_d      = err_q | frame_err_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_error_d = 1'b0;
        if (byte_stb_q) begin
            if (dec[4]) begin
                acc_d = (acc_q << 4) | RESOLUTION'(dec[3:0]);
                if (cnt_q != CNT_SAT)
                    cnt_d = cnt_q + CW'(1);
            end else if (byte_q == 8'h0A) begin
                cnt_d = cnt_q;
            end else if (byte_q == 8'h0D) begin
                if (cnt_q == CNT_FULL && !err_q) begin
                    rx_data_d  = acc_q;
                    rx_valid_d = 1'b1;
                end else if (cnt_q != '0 || err_q) begin
                    rx_error_d = 1'b1;
                end
                acc_d = '0;
                cnt_d = '0;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            byte_q      <= 8'd0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            sync1_q     <= RX;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_error = rx_error_q;

endmodule

// File: tb/tb_rx_word.sv
// Scoreboard bench for rx_word: UART frames driven in, expected word/error
// events queued at stimulus time and matched against DUT strobes.
`timescale 1ns/1ps
module tb_rx_word;
    localparam int RES = 32;
    localparam int CPB = 8;
    localparam longint LATENCY = 4 + CPB / 2 + 9 * CPB;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           RX = 1'b1;
    logic [RES-1:0] rx_data;
    logic           rx_valid;
    logic           rx_error;

    rx_word #(.RESOLUTION(RES), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           is_err;
        logic [RES-1:0] data;
    } exp_t;

    exp_t     exp_q[$];
    int       n_checks = 0;
    int       n_fail = 0;
    int       n_valid = 0;
    int       n_error = 0;
    longint   cyc = 0;
    longint   last_valid_cyc = 0;
    logic [RES-1:0] good;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (rx_valid || rx_error)) begin
                n_checks++;
                if (rx_valid && rx_error) begin
                    n_fail++;
                    $display("FAIL strobe_exclusive: valid=%b error=%b, required not both", rx_valid, rx_error);
                end
                if (rx_valid) begin
                    n_valid++;
                    last_valid_cyc = cyc;
                end
                if (rx_error) n_error++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: valid=%b error=%b data=%h, required no strobe", rx_valid, rx_error, rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_error !== e.is_err || rx_data !== e.data) begin
                        n_fail++;
                        $display("FAIL scoreboard: error=%b data=%h, required error=%b data=%h", rx_error, rx_data, e.is_err, e.data);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic send_cr();
        send_byte(8'h0D, 1'b1);
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic is_err, input logic [RES-1:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 40 * CPB) begin
            @(posedge clk);
            #1;
            t++;
        end
        idle(2 * CPB);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rx_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", rx_data); end
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", rx_valid); end
        n_checks++;
        if (rx_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b, required 0", rx_error); end
        rst_n = 1'b1;
        idle(2 * CPB);
    endtask

    task automatic test_basic();
        int v0, e0;
        longint c0;
        v0 = n_valid; e0 = n_error;
        push_exp(1'b0, 32'hDEADBEEF);
        send_str("DEADBEEF");
        c0 = cyc;
        send_cr();
        drain();
        n_checks++;
        if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d, required 1", n_valid - v0); end
        n_checks++;
        if (n_error - e0 !== 0) begin n_fail++; $display("FAIL basic_error_count: got %0d, required 0", n_error - e0); end
        n_checks++;
        if (rx_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_data: got %h, required deadbeef", rx_data); end
        n_checks++;
        if (last_valid_cyc - c0 !== LATENCY) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, required %0d", last_valid_cyc - c0, LATENCY);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL basic_pending: got %0d, required 0", exp_q.size()); exp_q.delete(); end
        good = 32'hDEADBEEF;
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = n_valid;
        push_exp(1'b0, 32'h0000001A);
        push_exp(1'b0, 32'hFFFFFFFF);
        send_str("0000001a");
        send_cr();
        send_byte(8'h0A, 1'b1);
        send_str("FFFFFFFF");
        send_cr();
        drain();
        n_checks++;
        if (n_valid - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d, required 2", n_valid - v0); end
        n_checks++;
        if (rx_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL b2b_data: got %h, required ffffffff", rx_data); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); exp_q.delete(); end
        good = 32'hFFFFFFFF;
    endtask

    task automatic test_invalid();
        string cases [4];
        logic  errs  [4];
        int    e0;
        cases = '{"12G45678", "123", "123456789", ""};
        errs  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            push_exp(1'b0, 32'h12345678);
            send_str("12345678");
            send_cr();
            drain();
            good = 32'h12345678;
            e0 = n_error;
            if (errs[k]) push_exp(1'b1, good);
            send_str(cases[k]);
            send_cr();
            drain();
            n_checks++;
            if (n_error - e0 !== int'(errs[k])) begin
                n_fail++;
                $display("FAIL invalid_%0d_error_count: got %0d, required %0d", k, n_error - e0, int'(errs[k]));
            end
            n_checks++;
            if (rx_data !== good) begin n_fail++; $display("FAIL invalid_%0d_data: got %h, required %h", k, rx_data, good); end
            n_checks++;
            if (exp_q.size() !== 0) begin n_fail++; $display("FAIL invalid_%0d_pending: got %0d, required 0", k, exp_q.size()); exp_q.delete(); end
        end
    endtask

    task automatic test_framing();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        push_exp(1'b1, good);
        send_str("AB");
        send_byte(8'h31, 1'b0);
        idle(2 * CPB);
        send_str("CDEF01");
        send_cr();
        drain();
        n_checks++;
        if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL framing_valid_count: got %0d, required 0", n_valid - v0); end
        n_checks++;
        if (n_error - e0 !== 1) begin n_fail++; $display("FAIL framing_error_count: got %0d, required 1", n_error - e0); end
        push_exp(1'b0, 32'h00000005);
        send_str("00000005");
        send_cr();
        drain();
        n_checks++;
        if (rx_data !== 32'h00000005) begin n_fail++; $display("FAIL framing_recover_data: got %h, required 00000005", rx_data); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL framing_pending: got %0d, required 0", exp_q.size()); exp_q.delete(); end
        good = 32'h00000005;
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        RX = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(3 * CPB);
        n_checks++;
        if ((n_valid - v0) + (n_error - e0) !== 0) begin
            n_fail++;
            $display("FAIL glitch_strobes: got %0d, required 0", (n_valid - v0) + (n_error - e0));
        end
        n_checks++;
        if (rx_data !== good) begin n_fail++; $display("FAIL glitch_data: got %h, required %h", rx_data, good); end
        push_exp(1'b0, 32'h0BADF00D);
        send_str("0BADF00D");
        send_cr();
        drain();
        n_checks++;
        if (rx_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL glitch_recover_data: got %h, required 0badf00d", rx_data); end
        good = 32'h0BADF00D;
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] b;
        int v0;
        b = 8'h42;
        send_str("CAFE");
        RX = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            RX = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (rx_data !== '0 || rx_valid !== 1'b0 || rx_error !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: data=%h valid=%b error=%b, required all 0", rx_data, rx_valid, rx_error);
        end
        RX = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2 * CPB);
        v0 = n_valid;
        push_exp(1'b0, 32'hCAFEBABE);
        send_str("CAFEBABE");
        send_cr();
        drain();
        n_checks++;
        if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL midreset_valid_count: got %0d, required 1", n_valid - v0); end
        n_checks++;
        if (rx_data !== 32'hCAFEBABE) begin n_fail++; $display("FAIL midreset_data: got %h, required cafebabe", rx_data); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL midreset_pending: got %0d, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        good = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_invalid();
        test_framing();
        test_glitch();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
